// File: rtl/alu.sv
// 32-bit execute-stage ALU: add/sub/and/or/sll/sra with registered result and compare flags.
// Optional ALU_SRL_EN macro enables opcode 00110 as logical right shift.
module alu (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] data_operandA,
  input  logic [31:0] data_operandB,
  input  logic [4:0]  ctrl_ALUopcode,
  input  logic [4:0]  ctrl_shiftamt,
  output logic [31:0] data_result,
  output logic        isNotEqual,
  output logic        isLessThan,
  output logic        overflow
);

  typedef enum logic [4:0] {
    OP_ADD = 5'b00000,
    OP_SUB = 5'b00001,
    OP_AND = 5'b00010,
    OP_OR  = 5'b00011,
    OP_SLL = 5'b00100,
    OP_SRA = 5'b00101,
    OP_SRL = 5'b00110
  } op_e;

  logic [31:0] sum, diff;
  logic        add_ovf, sub_ovf;

  logic [31:0] result_d, result_q;
  logic        ne_d, ne_q;
  logic        lt_d, lt_q;
  logic        ovf_d, ovf_q;

  assign sum     = data_operandA + data_operandB;
  assign diff    = data_operandA + ~data_operandB + 32'd1;
  assign add_ovf = (data_operandA[31] == data_operandB[31]) && (sum[31]  != data_operandA[31]);
  assign sub_ovf = (data_operandA[31] != data_operandB[31]) && (diff[31] != data_operandA[31]);

  // Compare flags come from the subtractor every cycle, whatever the opcode.
  assign ne_d = |diff;
  assign lt_d = diff[31] ^ sub_ovf;

  always_comb begin
    // NOTE: defaults first so every path assigns every output; no latches.
    result_d = '0;
    ovf_d    = 1'b0;
    case (ctrl_ALUopcode)
      OP_ADD: begin
        result_d = sum;
        ovf_d    = add_ovf;
      end
      OP_SUB: begin
        result_d = diff;
        ovf_d    = sub_ovf;
      end
      OP_AND: result_d = data_operandA & data_operandB;
      OP_OR:  result_d = data_operandA | data_operandB;
      OP_SLL: result_d = data_operandA << ctrl_shiftamt;
      OP_SRA: result_d = $signed(data_operandA) >>> ctrl_shiftamt;
`ifdef ALU_SRL_EN
      OP_SRL: result_d = data_operandA >> ctrl_shiftamt;
`endif
      default: result_d = '0;
    endcase
  end

  always_ff @(posedge clock) begin
    // NOTE: non-blocking assignments for all state so every register sees pre-edge values.
    if (reset) begin
      result_q <= '0;
      ne_q     <= 1'b0;
      lt_q     <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      result_q <= result_d;
      ne_q     <= ne_d;
      lt_q     <= lt_d;
      ovf_q    <= ovf_d;
    end
  end

  assign data_result = result_q;
  assign isNotEqual  = ne_q;
  assign isLessThan  = lt_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed vector table, reset sequences, randomized model compare.
module tb_alu;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] data_operandA, data_operandB;
  logic [4:0]  ctrl_ALUopcode, ctrl_shiftamt;
  logic [31:0] data_result;
  logic        isNotEqual, isLessThan, overflow;

  int pass_cnt = 0;
  int total_cnt = 0;

  alu dut (
    .clock          (clock),
    .reset          (reset),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .ctrl_ALUopcode (ctrl_ALUopcode),
    .ctrl_shiftamt  (ctrl_shiftamt),
    .data_result    (data_result),
    .isNotEqual     (isNotEqual),
    .isLessThan     (isLessThan),
    .overflow       (overflow)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  op;
    logic [4:0]  sh;
    logic [31:0] r;
    logic        ne;
    logic        lt;
    logic        ov;
  } vec_t;

  vec_t vecs[$];

  localparam longint MAX_S = 2147483647;
  localparam longint MIN_S = -MAX_S - 1;

`ifdef ALU_SRL_EN
  localparam bit SRL_EN = 1'b1;
`else
  localparam bit SRL_EN = 1'b0;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask

  task automatic apply(input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] op, input logic [4:0] sh);
    data_operandA  = a;
    data_operandB  = b;
    ctrl_ALUopcode = op;
    ctrl_shiftamt  = sh;
    @(posedge clock);
    #1;
  endtask

  task automatic check_all(input string tag, input logic [31:0] r,
                           input logic ne, input logic lt, input logic ov);
    check({tag, ".result"},   data_result, r);
    check({tag, ".notequal"}, {31'b0, isNotEqual}, {31'b0, ne});
    check({tag, ".lessthan"}, {31'b0, isLessThan}, {31'b0, lt});
    check({tag, ".overflow"}, {31'b0, overflow},   {31'b0, ov});
  endtask

  // Reference computed with 64-bit signed arithmetic rather than bit-level flag logic.
  task automatic model(input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] op, input logic [4:0] sh,
                       output logic [31:0] r, output logic ne,
                       output logic lt, output logic ov);
    longint sa, sb, s;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r  = 32'd0;
    ov = 1'b0;
    ne = (a != b);
    lt = (sa < sb);
    case (op)
      5'd0: begin s = sa + sb; r = s[31:0]; ov = (s > MAX_S) || (s < MIN_S); end
      5'd1: begin s = sa - sb; r = s[31:0]; ov = (s > MAX_S) || (s < MIN_S); end
      5'd2: r = a & b;
      5'd3: r = a | b;
      5'd4: begin s = sa * (longint'(1) << sh); r = s[31:0]; end
      5'd5: begin
        s = sa;
        for (int i = 0; i < 32; i++) if (i < sh) s = (s < 0) ? -((-s + 1) / 2) : s / 2;
        r = s[31:0];
      end
      5'd6: if (SRL_EN) r = a / (32'd1 << sh);
      default: r = 32'd0;
    endcase
  endtask

  initial begin
    logic [31:0] er;
    logic        ene, elt, eov;
    logic [31:0] ra, rb;
    logic [4:0]  rop, rsh;

    reset = 1'b1;
    apply(32'd0, 32'd0, 5'd0, 5'd0);
    apply(32'h1234_5678, 32'h1, 5'd0, 5'd0);
    check_all("reset_state", 32'd0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;

    vecs.push_back('{a:32'd1343, b:32'd100000, op:5'd1, sh:5'd0,
                     r:32'hFFFE_7E9F, ne:1'b1, lt:1'b1, ov:1'b0});
    vecs.push_back('{a:32'h7FFF_FFFF, b:32'd1, op:5'd0, sh:5'd0,
                     r:32'h8000_0000, ne:1'b1, lt:1'b0, ov:1'b1});
    vecs.push_back('{a:32'hF0F0_F0F0, b:32'h0FF0_0FF0, op:5'd2, sh:5'd0,
                     r:32'h00F0_00F0, ne:1'b1, lt:1'b1, ov:1'b0});
    vecs.push_back('{a:32'hF0F0_F0F0, b:32'h0FF0_0FF0, op:5'd3, sh:5'd0,
                     r:32'hFFF0_FFF0, ne:1'b1, lt:1'b1, ov:1'b0});
    vecs.push_back('{a:32'h8000_0001, b:32'd0, op:5'd4, sh:5'd4,
                     r:32'h0000_0010, ne:1'b1, lt:1'b1, ov:1'b0});
    vecs.push_back('{a:32'h8000_0001, b:32'd0, op:5'd5, sh:5'd4,
                     r:32'hF800_0000, ne:1'b1, lt:1'b1, ov:1'b0});
    vecs.push_back('{a:32'h8000_0001, b:32'd0, op:5'd6, sh:5'd4,
                     r:(SRL_EN ? 32'h0800_0000 : 32'd0), ne:1'b1, lt:1'b1, ov:1'b0});
    vecs.push_back('{a:32'h8000_0000, b:32'd1, op:5'd1, sh:5'd0,
                     r:32'h7FFF_FFFF, ne:1'b1, lt:1'b1, ov:1'b1});
    vecs.push_back('{a:32'h8000_0000, b:32'd7, op:5'd5, sh:5'd31,
                     r:32'hFFFF_FFFF, ne:1'b1, lt:1'b1, ov:1'b0});
    vecs.push_back('{a:32'h1234_5678, b:32'h9, op:5'd4, sh:5'd0,
                     r:32'h1234_5678, ne:1'b1, lt:1'b0, ov:1'b0});
    vecs.push_back('{a:32'd9, b:32'd3, op:5'd17, sh:5'd2,
                     r:32'd0, ne:1'b1, lt:1'b0, ov:1'b0});
    vecs.push_back('{a:32'h8000_0000, b:32'h8000_0000, op:5'd0, sh:5'd0,
                     r:32'd0, ne:1'b0, lt:1'b0, ov:1'b1});

    foreach (vecs[i]) begin
      apply(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].sh);
      check_all($sformatf("vec%0d", i), vecs[i].r, vecs[i].ne, vecs[i].lt, vecs[i].ov);
    end

    // Equal operands, then reset discards whatever is in flight.
    apply(32'd5, 32'd5, 5'd1, 5'd0);
    check_all("equal_sub", 32'd0, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    apply(32'h7FFF_FFFF, 32'd1, 5'd0, 5'd0);
    check_all("reset_midop", 32'd0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    apply(32'd3, 32'd4, 5'd0, 5'd0);
    check_all("first_after_reset", 32'd7, 1'b1, 1'b1, 1'b0);

    // Back-to-back ops: each edge carries only the inputs sampled at it.
    apply(32'd10, 32'd20, 5'd0, 5'd0);
    check_all("b2b_0", 32'd30, 1'b1, 1'b1, 1'b0);
    apply(32'd10, 32'd20, 5'd3, 5'd0);
    check_all("b2b_1", 32'd30, 1'b1, 1'b1, 1'b0);
    apply(32'hFFFF_FFFF, 32'd1, 5'd2, 5'd0);
    check_all("b2b_2", 32'd1, 1'b1, 1'b1, 1'b0);

    for (int n = 0; n < 300; n++) begin
      ra  = $urandom;
      rb  = $urandom;
      rop = 5'($urandom_range(0, 7));
      rsh = 5'($urandom_range(0, 31));
      case ($urandom_range(0, 7))
        0: rb = ra;
        1: ra = 32'h8000_0000;
        2: rb = 32'h7FFF_FFFF;
        3: rop = 5'($urandom_range(0, 31));
        default: ;
      endcase
      model(ra, rb, rop, rsh, er, ene, elt, eov);
      apply(ra, rb, rop, rsh);
      check_all($sformatf("rnd%0d_op%0d", n, rop), er, ene, elt, eov);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
